// File: rtl/fir_pkg.sv
// Shared FIR datapath types and default sizing.
package fir_pkg;

    localparam int unsigned FIR_N    = 16;
    localparam int unsigned FIR_TAPS = 8;
    localparam int unsigned IDX_W    = $clog2(FIR_TAPS);
    localparam int unsigned ACC_W    = FIR_N + IDX_W + 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;

    typedef logic signed [FIR_N-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/fir_saturate.sv
// Combinational signed clamp from a wide accumulator down to the sample width.
module fir_saturate #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout_c
);

    localparam int unsigned TOP_W = IN_W - OUT_W + 1;

    logic [TOP_W-1:0] top_bits;

    assign top_bits = din[IN_W-1:OUT_W-1];

    // In range exactly when every bit above the output sign bit matches it.
    always_comb begin
        dout_c = din[OUT_W-1:0];
        if (!((top_bits == '0) || (top_bits == '1))) begin
            if (din[IN_W-1]) dout_c = {1'b1, {(OUT_W-1){1'b0}}};
            else             dout_c = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: walks one tap per clock through an external multiplier
// and emits one saturated output per accepted sample.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned N    = FIR_N,
    parameter int unsigned TAPS = FIR_TAPS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [N-1:0]        in_sample,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [N-1:0]        coef_data,
    output logic signed [N-1:0]        mul_a,
    output logic signed [N-1:0]        mul_b,
    input  logic signed [N-1:0]        mul_p,
    output logic signed [N-1:0]        out_sample,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned IW = $clog2(TAPS);
    localparam int unsigned AW = N + IW + 1;

    fir_state_t          state_q;
    logic signed [N-1:0] x_q [TAPS];
    logic signed [N-1:0] h_q [TAPS];
    logic signed [AW-1:0] acc_q;
    logic [IW-1:0]        idx_q;

    logic signed [AW-1:0] acc_next_c;
    logic signed [N-1:0]  sat_c;

    assign acc_next_c = acc_q + AW'(mul_p);

    fir_saturate #(
        .IN_W  (AW),
        .OUT_W (N)
    ) u_sat (
        .din    (acc_next_c),
        .dout_c (sat_c)
    );

    // Multiplier operands track idx directly so the product returns in the same cycle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == MAC) begin
            mul_a = x_q[idx_q];
            mul_b = h_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready   <= 1'b0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            for (int k = 0; k < int'(TAPS); k++) begin
                x_q[k] <= '0;
                h_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (coef_we) h_q[coef_addr] <= coef_data;
                    if (in_valid && in_ready) begin
                        x_q[0] <= in_sample;
                        for (int k = 1; k < int'(TAPS); k++) x_q[k] <= x_q[k-1];
                        acc_q    <= '0;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_next_c;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(TAPS - 1)) begin
                        idx_q      <= '0;
                        out_sample <= sat_c;
                        out_valid  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
